// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: a shift-register scoreboard of in-flight destinations drives stall/bubble control.
// Optional macro FORWARD_EN adds registered EX forwarding selects so that only load-use hazards stall.
module hazard_scoreboard #(
    parameter int REG_W      = 5,
    parameter int PIPE_DEPTH = 3,
    parameter int WB_BYPASS  = 0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_regwrite,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_memread,
    input  logic             flush,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             control_mux,
    output logic             hazard,
    output logic [CNT_W-1:0] stall_count,
    output logic [2:0]       ex_fwd_a_sel,
    output logic [2:0]       ex_fwd_b_sel
);
    localparam int CMP_N = PIPE_DEPTH - WB_BYPASS;

    if (PIPE_DEPTH < 2 || PIPE_DEPTH > 8) begin : gBadDepth
        $error("hazard_scoreboard: PIPE_DEPTH must be in 2..8");
    end

    logic [PIPE_DEPTH-1:0]            entValid_q;
    logic [PIPE_DEPTH-1:0]            entLoad_q;
    logic [PIPE_DEPTH-1:0][REG_W-1:0] entRd_q;
    logic [CNT_W-1:0]                 stallCount_q;
    logic [PIPE_DEPTH-1:0]            matchRs;
    logic [PIPE_DEPTH-1:0]            matchRt;
    logic                             stall;
    logic                             insert;
    logic                             unusedSink;

    always_comb begin
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            matchRs[i] = entValid_q[i] && (entRd_q[i] == id_rs) && (id_rs != '0);
            matchRt[i] = entValid_q[i] && (entRd_q[i] == id_rt) && (id_rt != '0);
        end
    end

`ifdef FORWARD_EN
    // Only a load still in EX cannot be bypassed in time; everything else forwards.
    assign stall = id_valid && !flush && entLoad_q[0] &&
                   ((id_uses_rs && matchRs[0]) || (id_uses_rt && matchRt[0]));
`else
    logic anyHit;

    always_comb begin
        anyHit = 1'b0;
        for (int i = 0; i < CMP_N; i++) begin
            anyHit = anyHit | (id_uses_rs && matchRs[i]) | (id_uses_rt && matchRt[i]);
        end
    end

    assign stall = id_valid && !flush && anyHit;
`endif

    // A stalled or flushed instruction never enters; the shift itself never freezes.
    assign insert = id_valid && id_regwrite && (id_rd != '0) && !stall && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            entValid_q   <= '0;
            entLoad_q    <= '0;
            entRd_q      <= '0;
            stallCount_q <= '0;
        end else begin
            entValid_q <= {entValid_q[PIPE_DEPTH-2:0], insert};
            entLoad_q  <= {entLoad_q[PIPE_DEPTH-2:0], insert && id_memread};
            entRd_q    <= {entRd_q[PIPE_DEPTH-2:0], {REG_W{insert}} & id_rd};
            if (stall && (stallCount_q != '1)) begin
                stallCount_q <= stallCount_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

`ifdef FORWARD_EN
    logic [2:0] fwdASel_d;
    logic [2:0] fwdBSel_d;
    logic [2:0] fwdASel_q;
    logic [2:0] fwdBSel_q;

    // Scan oldest to youngest so the youngest matching producer overwrites.
    always_comb begin
        fwdASel_d = '0;
        fwdBSel_d = '0;
        if (id_valid && !stall && !flush) begin
            for (int i = PIPE_DEPTH - 2; i >= 0; i--) begin
                if (id_uses_rs && matchRs[i]) fwdASel_d = 3'(i + 1);
                if (id_uses_rt && matchRt[i]) fwdBSel_d = 3'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fwdASel_q <= '0;
            fwdBSel_q <= '0;
        end else begin
            fwdASel_q <= fwdASel_d;
            fwdBSel_q <= fwdBSel_d;
        end
    end

    assign ex_fwd_a_sel = fwdASel_q;
    assign ex_fwd_b_sel = fwdBSel_q;
`else
    assign ex_fwd_a_sel = '0;
    assign ex_fwd_b_sel = '0;
`endif

    // Some scoreboard bits feed no compare in certain configurations (WB entry, load flags).
    assign unusedSink = ^{entValid_q, entLoad_q, entRd_q, matchRs, matchRt};

    assign pc_write    = !stall;
    assign if_id_write = !stall;
    assign hazard      = stall;
    assign control_mux = stall || flush;
    assign stall_count = stallCount_q;
endmodule
